// File: rtl/vec_pkg.sv
// Shared types and constants for the vector control sequencer.
// Holds datapath widths, instruction class and FSM state encodings, and fixed ALU register slots.
package vec_pkg;

  localparam int DATA_W = 512;
  localparam int MEM_AW = 9;
  localparam int REG_AW = 2;

  typedef enum logic [1:0] {
    CLS_LOAD  = 2'b00,
    CLS_STORE = 2'b01,
    CLS_ALU   = 2'b10,
    CLS_NOP   = 2'b11
  } instr_class_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LD_ADDR = 3'd1,
    ST_LD_WB   = 3'd2,
    ST_ST_WR   = 3'd3,
    ST_ALU_LO  = 3'd4,
    ST_ALU_HI  = 3'd5
  } state_e;

  localparam logic [REG_AW-1:0] ALU_SRC_A  = 2'd0;
  localparam logic [REG_AW-1:0] ALU_SRC_B  = 2'd1;
  localparam logic [REG_AW-1:0] ALU_DST_LO = 2'd2;
  localparam logic [REG_AW-1:0] ALU_DST_HI = 2'd3;

endpackage

// File: rtl/vector_op_sequencer.sv
// Multi-cycle sequencer: takes one decoded LOAD/STORE/ALU/NOP at a time and drives regfile, ALU and memory controls.
// Latency fire->done: NOP/STORE 1 cycle, LOAD/ALU 2 cycles; instr_ready only in IDLE, so offers wait until then.
module vector_op_sequencer #(
  parameter int DATA_W = vec_pkg::DATA_W,
  parameter int MEM_AW = vec_pkg::MEM_AW,
  parameter int REG_AW = vec_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [1:0]        instr_class,
  input  logic [1:0]        instr_alu_op,
  input  logic [REG_AW-1:0] instr_reg,
  input  logic [MEM_AW-1:0] instr_mem_addr,
  output logic [REG_AW-1:0] reg_a_addr,
  output logic [REG_AW-1:0] reg_b_addr,
  input  logic [DATA_W-1:0] reg_a_data,
  output logic [REG_AW-1:0] reg_wr_addr,
  output logic [DATA_W-1:0] reg_wr_data,
  output logic              reg_wr_en,
  output logic [1:0]        alu_op,
  input  logic [DATA_W-1:0] alu_lo,
  input  logic [DATA_W-1:0] alu_hi,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_wr_en,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              busy,
  output logic              done
);

  import vec_pkg::*;

  state_e            state_q, state_d;
  logic [1:0]        op_q;
  logic [REG_AW-1:0] reg_q;
  logic [MEM_AW-1:0] addr_q;
  logic              nop_done_q;
  logic              fire;

  // Reset wins over a simultaneous offer, so ready is masked by rst.
  assign instr_ready = (state_q == ST_IDLE) && !rst;
  assign fire        = instr_valid && instr_ready;
  assign busy        = (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      reg_q      <= '0;
      addr_q     <= '0;
      nop_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      nop_done_q <= fire && (instr_class == CLS_NOP);
      if (fire) begin
        op_q   <= instr_alu_op;
        reg_q  <= instr_reg;
        addr_q <= instr_mem_addr;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    reg_a_addr  = '0;
    reg_b_addr  = '0;
    reg_wr_addr = '0;
    reg_wr_data = '0;
    reg_wr_en   = 1'b0;
    alu_op      = '0;
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_wr_en   = 1'b0;
    done        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // NOP never leaves IDLE; its done pulse comes from nop_done_q.
        done = nop_done_q;
        if (fire) begin
          case (instr_class_e'(instr_class))
            CLS_LOAD:  state_d = ST_LD_ADDR;
            CLS_STORE: state_d = ST_ST_WR;
            CLS_ALU:   state_d = ST_ALU_LO;
            default:   state_d = ST_IDLE;
          endcase
        end
      end
      ST_LD_ADDR: begin
        mem_addr = addr_q;
        state_d  = ST_LD_WB;
      end
      ST_LD_WB: begin
        mem_addr    = addr_q;
        reg_wr_en   = 1'b1;
        reg_wr_addr = reg_q;
        reg_wr_data = mem_rd_data;
        done        = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_ST_WR: begin
        reg_a_addr  = reg_q;
        mem_addr    = addr_q;
        mem_wr_data = reg_a_data;
        mem_wr_en   = 1'b1;
        done        = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_ALU_LO: begin
        reg_a_addr  = ALU_SRC_A;
        reg_b_addr  = ALU_SRC_B;
        alu_op      = op_q;
        reg_wr_addr = ALU_DST_LO;
        reg_wr_data = alu_lo;
        reg_wr_en   = 1'b1;
        state_d     = ST_ALU_HI;
      end
      ST_ALU_HI: begin
        reg_a_addr  = ALU_SRC_A;
        reg_b_addr  = ALU_SRC_B;
        alu_op      = op_q;
        reg_wr_addr = ALU_DST_HI;
        reg_wr_data = alu_hi;
        reg_wr_en   = 1'b1;
        done        = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vector_op_sequencer.sv
// Bench for vector_op_sequencer: directed plan steps then random traffic against a per-cycle schedule model.
module tb_vector_op_sequencer;
  import vec_pkg::*;

  logic              clk;
  logic              rst;
  logic              instr_valid;
  logic              instr_ready;
  logic [1:0]        instr_class;
  logic [1:0]        instr_alu_op;
  logic [REG_AW-1:0] instr_reg;
  logic [MEM_AW-1:0] instr_mem_addr;
  logic [REG_AW-1:0] reg_a_addr, reg_b_addr, reg_wr_addr;
  logic [DATA_W-1:0] reg_a_data, reg_wr_data, alu_lo, alu_hi, mem_wr_data, mem_rd_data;
  logic              reg_wr_en, mem_wr_en, busy, done;
  logic [1:0]        alu_op;
  logic [MEM_AW-1:0] mem_addr;

  vector_op_sequencer dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_class(instr_class), .instr_alu_op(instr_alu_op),
    .instr_reg(instr_reg), .instr_mem_addr(instr_mem_addr),
    .reg_a_addr(reg_a_addr), .reg_b_addr(reg_b_addr), .reg_a_data(reg_a_data),
    .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .reg_wr_en(reg_wr_en),
    .alu_op(alu_op), .alu_lo(alu_lo), .alu_hi(alu_hi),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
    .mem_rd_data(mem_rd_data), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Each accepted instruction becomes a list of cycle kinds it will occupy after the fire edge.
  localparam int K_LD1 = 1, K_LD2 = 2, K_ST = 3, K_A1 = 4, K_A2 = 5, K_NOP = 6;
  typedef struct {
    int         kind;
    logic [1:0] op;
    logic [1:0] rg;
    logic [8:0] ad;
  } item_t;

  item_t sched[$];
  int    checks   = 0;
  int    failures = 0;
  bit    last_fire;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < DATA_W / 32; i++) begin
      reg_a_data[i*32 +: 32]  = $urandom;
      alu_lo[i*32 +: 32]      = $urandom;
      alu_hi[i*32 +: 32]      = $urandom;
      mem_rd_data[i*32 +: 32] = $urandom;
    end
  endtask

  // One cycle: drive, check just before the edge, then advance the model across the edge.
  task automatic step(input logic r, input logic v, input logic [1:0] cls, input logic [1:0] op,
                      input logic [1:0] rg, input logic [8:0] ad);
    item_t it;
    int    k;
    logic  e_ready, e_busy, e_done, e_rwe, e_mwe;
    logic [1:0] e_ra, e_rb, e_rwa, e_op;
    logic [8:0] e_ma;
    logic [DATA_W-1:0] e_rwd, e_mwd;
    rst = r; instr_valid = v; instr_class = cls; instr_alu_op = op;
    instr_reg = rg; instr_mem_addr = ad;
    #3;
    k = (sched.size() > 0) ? sched[0].kind : 0;
    if (sched.size() > 0) it = sched[0];
    else begin it.op = 0; it.rg = 0; it.ad = 0; end
    e_ready = ((k == 0) || (k == K_NOP)) && !r;
    e_busy = (k != 0) && (k != K_NOP);
    e_done = (k == K_LD2) || (k == K_ST) || (k == K_A2) || (k == K_NOP);
    e_rwe = (k == K_LD2) || (k == K_A1) || (k == K_A2);
    e_mwe = (k == K_ST);
    e_ra = (k == K_ST) ? it.rg : 2'd0;
    e_rb = (k == K_A1 || k == K_A2) ? 2'd1 : 2'd0;
    e_op = (k == K_A1 || k == K_A2) ? it.op : 2'd0;
    e_rwa = (k == K_LD2) ? it.rg : (k == K_A1) ? 2'd2 : (k == K_A2) ? 2'd3 : 2'd0;
    e_ma = (k == K_LD1 || k == K_LD2 || k == K_ST) ? it.ad : 9'd0;
    e_rwd = (k == K_LD2) ? mem_rd_data : (k == K_A1) ? alu_lo : (k == K_A2) ? alu_hi : '0;
    e_mwd = (k == K_ST) ? reg_a_data : '0;
    chk("instr_ready", DATA_W'(instr_ready), DATA_W'(e_ready));
    chk("busy", DATA_W'(busy), DATA_W'(e_busy));
    chk("done", DATA_W'(done), DATA_W'(e_done));
    chk("reg_wr_en", DATA_W'(reg_wr_en), DATA_W'(e_rwe));
    chk("mem_wr_en", DATA_W'(mem_wr_en), DATA_W'(e_mwe));
    chk("reg_a_addr", DATA_W'(reg_a_addr), DATA_W'(e_ra));
    chk("reg_b_addr", DATA_W'(reg_b_addr), DATA_W'(e_rb));
    chk("alu_op", DATA_W'(alu_op), DATA_W'(e_op));
    chk("reg_wr_addr", DATA_W'(reg_wr_addr), DATA_W'(e_rwa));
    chk("mem_addr", DATA_W'(mem_addr), DATA_W'(e_ma));
    chk("reg_wr_data", reg_wr_data, e_rwd);
    chk("mem_wr_data", mem_wr_data, e_mwd);
    last_fire = v && e_ready;
    @(posedge clk);
    #1;
    if (r) sched.delete();
    else begin
      if (sched.size() > 0) void'(sched.pop_front());
      if (last_fire) begin
        it.op = op; it.rg = rg; it.ad = ad;
        case (cls)
          2'b00: begin it.kind = K_LD1; sched.push_back(it); it.kind = K_LD2; sched.push_back(it); end
          2'b01: begin it.kind = K_ST; sched.push_back(it); end
          2'b10: begin it.kind = K_A1; sched.push_back(it); it.kind = K_A2; sched.push_back(it); end
          default: begin it.kind = K_NOP; sched.push_back(it); end
        endcase
      end
    end
  endtask

  logic [DATA_W-1:0] dead_pat;
  logic              p_v;
  logic [1:0]        p_cls, p_op, p_rg;
  logic [8:0]        p_ad;

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr_class = 0; instr_alu_op = 0;
    instr_reg = 0; instr_mem_addr = 0;
    rand_data();
    @(posedge clk); #1;
    step(1, 1, 2'b00, 0, 0, 9'h0);
    step(1, 0, 0, 0, 0, 0);

    // LOAD r1 <- mem[0x1A5]
    for (int i = 0; i < DATA_W / 32; i++) dead_pat[i*32 +: 32] = 32'hDEADBEEF;
    step(0, 1, 2'b00, 2'b11, 2'd1, 9'h1A5);
    rand_data(); step(0, 0, 0, 0, 0, 0);
    mem_rd_data = dead_pat; step(0, 0, 0, 0, 0, 0);
    chk("load_wb_data_const", reg_wr_data, '0);

    // STORE r3 -> mem[0]
    step(0, 1, 2'b01, 0, 2'd3, 9'h000);
    reg_a_data = '1; step(0, 0, 0, 0, 0, 0);

    // ALU op 2
    step(0, 1, 2'b10, 2'b10, 0, 0);
    alu_lo = 5; alu_hi = 7; step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // LOAD then STORE held back-to-back
    rand_data();
    step(0, 1, 2'b00, 0, 2'd2, 9'h0F0);
    step(0, 1, 2'b01, 0, 2'd0, 9'h1FF);
    step(0, 1, 2'b01, 0, 2'd0, 9'h1FF);
    step(0, 1, 2'b01, 0, 2'd0, 9'h1FF);
    step(0, 0, 0, 0, 0, 0);

    // Reset during ALU_LO, with a simultaneous offer that must be ignored
    step(0, 1, 2'b10, 2'b01, 0, 0);
    step(1, 1, 2'b00, 0, 2'd1, 9'h011);
    step(0, 0, 0, 0, 0, 0);

    // NOP
    step(0, 1, 2'b11, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Random traffic; an offered instruction is held until it fires.
    p_v = 0; p_cls = 0; p_op = 0; p_rg = 0; p_ad = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!p_v) begin
        p_cls = 2'($urandom); p_op = 2'($urandom); p_rg = 2'($urandom); p_ad = 9'($urandom);
        p_v = ($urandom_range(0, 2) != 0);
      end
      rand_data();
      step(($urandom_range(0, 39) == 0), p_v, p_cls, p_op, p_rg, p_ad);
      if (last_fire) p_v = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
